// File: rtl/scs8hd_tester_pkg.sv
// Shared types and constants for the library-cell vector tester.
// Holds the FSM state enum, drive bit positions and the a221oi truth table.
package scs8hd_tester_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam int A1_POS = 4;
   localparam int A2_POS = 3;
   localparam int B1_POS = 2;
   localparam int B2_POS = 1;
   localparam int C1_POS = 0;

   // Y = !(A1&A2 | B1&B2 | C1), indexed by the 5-bit drive vector
   localparam logic [31:0] TT_A221OI = 32'h00151515;

   function automatic logic a221oi_y(input logic [4:0] d);
      return !((d[A1_POS] & d[A2_POS]) | (d[B1_POS] & d[B2_POS]) | d[C1_POS]);
   endfunction

endpackage

// File: rtl/scs8hd_tester_ysync.sv
// Two-flop synchronizer for the cell output under test.
// Only instantiated when SCS8HD_TESTER_YSYNC_EN is defined.
module scs8hd_tester_ysync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic r_s1;
   logic r_s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= d;
         r_s2 <= r_s1;
      end
   end

   assign q = r_s2;

endmodule

// File: rtl/scs8hd_cell_vector_tester.sv
// Exhaustive stimulus driver / response checker for a single-output cell.
// Optional SCS8HD_TESTER_YSYNC_EN adds a 2-flop y_in synchronizer (+2 settle).
module scs8hd_cell_vector_tester
   import scs8hd_tester_pkg::*;
#(
   parameter int N_IN   = 5,
   parameter int SETTLE = 2,
   parameter int TT_W   = 2**N_IN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [TT_W-1:0] expected,
   output logic [N_IN-1:0] drive,
   input  logic            y_in,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic [N_IN-1:0] first_fail_vec,
   output logic            first_fail_valid
);

   logic w_y;

`ifdef SCS8HD_TESTER_YSYNC_EN
   localparam int EXT = 2;

   scs8hd_tester_ysync u_ysync (
      .clk (clk),
      .rst (rst),
      .d   (y_in),
      .q   (w_y)
   );
`else
   localparam int EXT = 0;

   assign w_y = y_in;
`endif

   localparam int CW = $clog2(SETTLE + EXT + 1) + 1;
   localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE - 1 + EXT);
   localparam logic [N_IN-1:0] VEC_LAST = N_IN'(TT_W - 1);

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [TT_W-1:0] r_tt;
   logic [N_IN-1:0] r_vec;
   logic            r_busy;
   logic            r_done;
   logic            r_pass;
   logic [N_IN:0]   r_err;
   logic [N_IN-1:0] r_ffv;
   logic            r_ffvalid;
   logic            w_mis;

   assign w_mis = (w_y != r_tt[r_vec]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_tt      <= '0;
         r_vec     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_err     <= '0;
         r_ffv     <= '0;
         r_ffvalid <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_tt      <= expected;
                  r_err     <= '0;
                  r_ffv     <= '0;
                  r_ffvalid <= 1'b0;
                  r_done    <= 1'b0;
                  r_pass    <= 1'b0;
                  r_vec     <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= S_APPLY;
               end
            end
            S_APPLY: begin
               r_cnt   <= CNT_LOAD;
               r_state <= S_SETTLE;
            end
            S_SETTLE: begin
               if (r_cnt == '0) r_state <= S_SAMPLE;
               else r_cnt <= r_cnt - 1'b1;
            end
            S_SAMPLE: begin
               if (w_mis) begin
                  r_err <= r_err + (N_IN+1)'(1);
                  if (!r_ffvalid) begin
                     r_ffv     <= r_vec;
                     r_ffvalid <= 1'b1;
                  end
               end
               // Last vector terminates the run; the counter never wraps
               if (r_vec == VEC_LAST) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (r_err == '0) && !w_mis;
                  r_state <= S_DONE;
               end else begin
                  r_vec   <= r_vec + 1'b1;
                  r_state <= S_APPLY;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign drive            = r_vec;
   assign busy             = r_busy;
   assign done             = r_done;
   assign pass             = r_pass;
   assign err_count        = r_err;
   assign first_fail_vec   = r_ffv;
   assign first_fail_valid = r_ffvalid;

endmodule

// File: tb/tb_scs8hd_cell_vector_tester.sv
// Self-checking bench: a221oi-style cell model on drive/y_in, mismatch
// statistics predicted from table XOR and run length from vector period.
module tb_scs8hd_cell_vector_tester;

`ifdef SCS8HD_TESTER_YSYNC_EN
   localparam int PER = 6;
`else
   localparam int PER = 4;
`endif
   localparam int RUN = 32 * PER;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] expected = '0;
   logic [4:0]  drive;
   logic        y_in;
   logic        busy;
   logic        done;
   logic        pass;
   logic [5:0]  err_count;
   logic [4:0]  first_fail_vec;
   logic        first_fail_valid;

   logic [31:0] cell_tt;
   logic [31:0] good_tt;
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc;

   scs8hd_cell_vector_tester #(.N_IN(5), .SETTLE(2)) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .expected         (expected),
      .drive            (drive),
      .y_in             (y_in),
      .busy             (busy),
      .done             (done),
      .pass             (pass),
      .err_count        (err_count),
      .first_fail_vec   (first_fail_vec),
      .first_fail_valid (first_fail_valid)
   );

   always #5 clk = ~clk;

   assign y_in = cell_tt[drive];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".drive"}, 32'(drive), 0);
      chk({tag, ".busy"}, 32'(busy), 0);
      chk({tag, ".done"}, 32'(done), 0);
      chk({tag, ".pass"}, 32'(pass), 0);
      chk({tag, ".err"}, 32'(err_count), 0);
      chk({tag, ".ffv"}, 32'(first_fail_vec), 0);
      chk({tag, ".ffvalid"}, 32'(first_fail_valid), 0);
   endtask

   task automatic accept(input logic [31:0] e);
      @(negedge clk);
      expected = e;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      expected = $urandom;
      cyc = 0;
   endtask

   task automatic wait_done(input int budget);
      while (!done && cyc < budget) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic check_result(input string tag, input logic [31:0] e);
      logic [31:0] mask;
      int          ne;
      int          ff;
      mask = e ^ cell_tt;
      ne = $countones(mask);
      ff = 0;
      for (int i = 31; i >= 0; i--) if (mask[i]) ff = i;
      chk({tag, ".len"}, cyc, RUN);
      chk({tag, ".done"}, 32'(done), 1);
      chk({tag, ".busy"}, 32'(busy), 0);
      chk({tag, ".err"}, 32'(err_count), ne);
      chk({tag, ".pass"}, 32'(pass), (ne == 0) ? 1 : 0);
      chk({tag, ".ffvalid"}, 32'(first_fail_valid), (ne != 0) ? 1 : 0);
      chk({tag, ".ffv"}, 32'(first_fail_vec), ff);
      chk({tag, ".drive"}, 32'(drive), 31);
   endtask

   task automatic full_run(input string tag, input logic [31:0] e);
      accept(e);
      chk({tag, ".busy0"}, 32'(busy), 1);
      chk({tag, ".done0"}, 32'(done), 0);
      wait_done(RUN + 20);
      check_result(tag, e);
   endtask

   initial begin
      for (int v = 0; v < 32; v++) begin
         logic [4:0] d;
         d = 5'(v);
         good_tt[v] = !((d[4] & d[3]) | (d[2] & d[1]) | d[0]);
      end
      cell_tt = good_tt;

      repeat (3) @(posedge clk);
      #1;
      chk_reset("rst");
      @(negedge clk);
      rst = 1'b0;

      full_run("good", 32'h00151515);
      full_run("inv", 32'hFFEAEAEA);
      full_run("bit5", 32'h00151535);

      accept(32'h00151515);
      repeat (39) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_reset("abort");
      @(negedge clk);
      rst = 1'b0;
      full_run("after_abort", 32'h00151515);

      accept(32'h00151515);
      repeat (19) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      wait_done(RUN + 20);
      check_result("midstart", 32'h00151515);

      accept(32'h00151535);
      chk("restart.done", 32'(done), 0);
      chk("restart.busy", 32'(busy), 1);
      wait_done(RUN + 20);
      check_result("restart", 32'h00151535);

      for (int k = 0; k < 4; k++) begin
         logic [31:0] e;
         cell_tt = $urandom;
         e = (k[0]) ? $urandom : cell_tt ^ (32'h1 << $urandom_range(31, 0));
         full_run($sformatf("rnd%0d", k), e);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/scs8hd_cell_vector_tester.md
Name: scs8hd_cell_vector_tester

Overview:
- Stimulus driver and response checker for single-output combinational library cells (a221oi-class, up to 5 inputs).
- Drives every input combination onto the cell inputs, waits a programmable settle time, then samples the cell output.
- Compares each sample against a caller-supplied truth-table word, and reports pass/fail, mismatch count and the first failing vector.
- Instantiated in gate-level regression benches and on-chip cell-health test structures, on the input side of the cell under test.

Parameters:
- N_IN, 5, number of cell inputs driven (1..5).
- SETTLE, 2, cycles between driving a vector and sampling y_in (>=1).
- TT_W, 2**N_IN, truth-table width (derived; do not override).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  begin exhaustive run. Sampled only in IDLE or DONE.
- expected  input  TT_W  truth table; bit v = required Y for vector v. Latched at start.
- drive  output  N_IN  cell inputs. For N_IN=5: [4]=A1, [3]=A2, [2]=B1, [1]=B2, [0]=C1.
- y_in  input  1  cell output under test.
- busy  output  1  run in progress.
- done  output  1  run complete. Held until next accepted start or rst.
- pass  output  1  valid when done; 1 iff err_count==0.
- err_count  output  N_IN+1  number of mismatching vectors. Saturation is impossible (max TT_W).
- first_fail_vec  output  N_IN  index of lowest-numbered failing vector.
- first_fail_valid  output  1  at least one mismatch has been recorded.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; drive=0; busy=0; done=0; pass=0; err_count=0; first_fail_vec=0; first_fail_valid=0; settle counter=0; latched table=0.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE/DONE + start=1:
  - latch expected;
  - clear err_count, first_fail_*, done, pass;
  - drive=0; busy=1; go to APPLY.
- APPLY (1 cycle): drive holds the current vector; settle counter loads SETTLE-1; go to SETTLE.
- SETTLE: decrement the counter; at 0 go to SAMPLE. Net effect: y_in is sampled SETTLE cycles after drive changed.
- SAMPLE (1 cycle):
  - compare y_in against latched[vec];
  - on mismatch: err_count+=1; if !first_fail_valid, record vec and set first_fail_valid;
  - if vec==TT_W-1 go to DONE, else vec+=1, drive updates, go to APPLY.
- Vector period = SETTLE+2 cycles. Full run = TT_W*(SETTLE+2) cycles from the start-accept edge to the done-rise edge.
- DONE: busy=0; done=1; pass=(err_count==0); drive holds the last vector.
- Boundary rules:
  - start while busy is ignored.
  - start held high in DONE restarts every accept.
  - rst mid-run aborts immediately to reset values; no partial result is retained.
  - Vector counter never wraps. Termination happens at TT_W-1.
  - expected changing mid-run has no effect.

Optional Feature:
- SCS8HD_TESTER_YSYNC_EN defined:
  - y_in passes through a 2-flop synchronizer (reset 0) before compare;
  - SETTLE state count is extended by 2, so vector period = SETTLE+4.
- Undefined: y_in is compared directly, with period SETTLE+2.

Decomposition:
- Package scs8hd_tester_pkg holds:
  - the state enum;
  - the drive bit-position constants for A1/A2/B1/B2/C1;
  - the constant TT_A221OI = 32'h00151515, the expected table for Y=!(A1&A2 | B1&B2 | C1).
- One sub-module, scs8hd_tester_ysync: the 2-flop synchronizer, instantiated only under the macro.

Test Plan:
- Correct a221oi model on drive/y_in, expected=32'h00151515, SETTLE=2, start pulse → done after 128 cycles; pass=1; err_count=0; first_fail_valid=0.
- Same setup with expected=32'hFFEAEAEA (inverted table) → err_count=32; first_fail_vec=0; pass=0.
- expected=32'h00151535 (bit 5 flipped) → err_count=1; first_fail_vec=5; first_fail_valid=1.
- rst asserted at cycle 40 of a run → next cycle all outputs at reset values. A later start gives a clean full run with pass=1.
- start re-pulsed mid-run at cycle 20 → ignored; done still at cycle 128. Second start in DONE → done drops next cycle and the run restarts.
- SCS8HD_TESTER_YSYNC_EN defined, SETTLE=2 → run length 192 cycles. Correct model still gives pass=1.
